game_clock_ctrl: RTL and testbench
==================================

// Module: game_clock_ctrl
// PURPOSE
//  Run/pause/expire controller for the scoreboard game clock. Derives a 1 s tick from clk and
//  counts an MM:SS BCD value down from a loadable preset. Raises a timed buzzer at 00:00.
//  Drives the four MM:SS digit displays, the scoreboard status LEDs and the buzzer.
// PARAMETERS
//  CLK_FREQ        100_000_000  clk cycles per second tick (benches override to 10)
//  DEFAULT_PRESET  16'h1200     BCD MM:SS loaded at reset (12:00)
//  BUZZ_CYCLES     50_000_000   cycles buzzer stays high after expiry
// PORTS
//  clk         in   1   system clock
//  rst         in   1   asynchronous reset, active-low
//  start_p     in   1   one-cycle start/resume request
//  pause_p     in   1   one-cycle pause request
//  load_p      in   1   one-cycle preset load request
//  preset_bcd  in   16  BCD {m_tens,m_ones,s_tens,s_ones}, sampled on load_p
//  digits_bcd  out  16  current BCD MM:SS, same packing as preset_bcd
//  running     out  1   high in RUN
//  expired     out  1   high in EXPIRED
//  sec_tick    out  1   one-cycle pulse on each decrement
//  load_err    out  1   one-cycle pulse when a load is rejected
//  buzzer      out  1   high for BUZZ_CYCLES after expiry
// BEHAVIOUR
//  Reset (rst=0, async): state IDLE, digits_bcd=DEFAULT_PRESET, prescaler=0, buzz counter=0.
//   All 1-bit outputs 0. Reset mid-run aborts immediately with no tick and no buzzer.
//  States: IDLE, RUN, PAUSE, EXPIRED.
//   IDLE   : start_p and digits!=0000 -> RUN.
//            start_p with digits==0000 is ignored.
//   RUN    : pause_p -> PAUSE. Decrement that reaches 0000 -> EXPIRED.
//   PAUSE  : start_p -> RUN.
//   EXPIRED: load_p (valid) -> IDLE. start_p is ignored.
//  Priority within one cycle: load_p > pause_p > start_p.
//   load_p is acted on only in IDLE/PAUSE/EXPIRED and is ignored in RUN (no load_err).
//   If start_p and pause_p arrive together in RUN -> PAUSE.
//   If they arrive together in PAUSE -> RUN.
//   If load_p is accepted in PAUSE -> IDLE.
//  Load: the preset is valid when every nibble is <=9 and s_tens is <=5.
//   Valid: digits_bcd<=preset_bcd, prescaler<=0, buzzer<=0 on the next edge.
//   Invalid: digits unchanged, state unchanged, load_err pulses 1 cycle.
//  Prescaler: log2(CLK_FREQ)-bit counter, 0..CLK_FREQ-1. Advances only in RUN.
//   It holds its value in PAUSE so partial seconds are kept, and clears on accepted load.
//   The cycle it equals CLK_FREQ-1 in RUN: it wraps to 0, sec_tick=1 (registered),
//   and digits decrement on that same edge.
//  Decrement is BCD with borrow chain s_ones(0->9), s_tens(0->5), m_ones(0->9), m_tens(0->9).
//   A value of 0000 is never decremented (no wrap to 9959).
//  Expiry: the edge that makes digits 0000 sets EXPIRED. That edge also loads the buzz
//   counter and sets buzzer=1. buzzer falls after exactly BUZZ_CYCLES cycles, and also
//   falls on an accepted load.
//  Latency: inputs to state/outputs = 1 clk. There is no combinational path from input
//   to output.
// STRUCTURE
//  game_clock_pkg: state enum (2 b), BCD digit width 4, SEC_TENS_MAX=5, DIGIT_MAX=9.
//  Sub-module bcd_down_digit #(MAX): 4-bit digit with en, load, borrow_in, borrow_out,
//   is_zero. Instantiate it 4x in a borrow chain; the top holds the FSM, prescaler and
//   buzz counter.
// TESTING (CLK_FREQ=10, BUZZ_CYCLES=5)
//  1. Release reset -> digits 1200, all flags 0. Pulse start -> running=1.
//     After 10 clk: sec_tick pulse, digits 1159.
//  2. Load 0001 in IDLE, start -> after 10 clk digits 0000, expired=1, buzzer high 5 clk
//     then low. start_p ignored while expired.
//  3. Run from 0100, pause at prescaler=4, wait 50 clk (digits hold), resume ->
//     next tick after 6 clk, digits 0059.
//  4. Load 0960 in PAUSE -> load_err 1 clk, digits unchanged. Load 1300 in RUN ->
//     ignored, no load_err.
//  5. In RUN, start_p+pause_p in the same cycle -> PAUSE. In PAUSE, start_p+pause_p ->
//     RUN. In PAUSE, load_p+start_p -> IDLE with the preset loaded.
//  6. Assert rst mid-RUN at prescaler=7 -> immediate IDLE, digits 1200, no sec_tick,
//     buzzer 0.

Source files
------------

// File: rtl/game_clock_pkg.sv
// rtl/game_clock_pkg.sv - shared types and constants for the scoreboard game clock
package game_clock_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PAUSE   = 2'd2,
        ST_EXPIRED = 2'd3
    } state_t;

    localparam int DIGIT_W      = 4;
    localparam int SEC_TENS_MAX = 5;
    localparam int DIGIT_MAX    = 9;

    // A preset is usable only when it is a real MM:SS value
    function automatic logic preset_ok(input logic [15:0] p);
        return (p[15:12] <= 4'(DIGIT_MAX)) && (p[11:8] <= 4'(DIGIT_MAX)) &&
               (p[7:4] <= 4'(SEC_TENS_MAX)) && (p[3:0] <= 4'(DIGIT_MAX));
    endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// rtl/bcd_down_digit.sv - one BCD down-counting digit with borrow chaining
module bcd_down_digit
    import game_clock_pkg::*;
#(
    parameter int                 MAX     = DIGIT_MAX,
    parameter logic [DIGIT_W-1:0] RST_VAL = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               load,
    input  logic [DIGIT_W-1:0] load_val,
    input  logic               borrow_in,
    output logic [DIGIT_W-1:0] q,
    output logic               borrow_out,
    output logic               is_zero
);

    assign is_zero    = (q == '0);
    assign borrow_out = borrow_in & is_zero;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= RST_VAL;
        end else if (load) begin
            q <= load_val;
        end else if (en && borrow_in) begin
            q <= is_zero ? DIGIT_W'(MAX) : q - 1'b1;
        end
    end

endmodule

// File: rtl/game_clock_ctrl.sv
// rtl/game_clock_ctrl.sv - run/pause/expire game clock with 1 s prescaler, BCD countdown and buzzer
module game_clock_ctrl
    import game_clock_pkg::*;
#(
    parameter int          CLK_FREQ       = 100_000_000,
    parameter logic [15:0] DEFAULT_PRESET = 16'h1200,
    parameter int          BUZZ_CYCLES    = 50_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_p,
    input  logic        pause_p,
    input  logic        load_p,
    input  logic [15:0] preset_bcd,
    output logic [15:0] digits_bcd,
    output logic        running,
    output logic        expired,
    output logic        sec_tick,
    output logic        load_err,
    output logic        buzzer
);

    localparam int PW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
    localparam int BW = $clog2(BUZZ_CYCLES + 1);

    state_t         state_q, state_d;
    logic [PW-1:0]  presc_q;
    logic [BW-1:0]  buzz_cnt_q;
    logic           sec_tick_q, load_err_q, buzzer_q;
    logic [3:0]     borrow, zero;

    logic in_run, wrap, load_ok, load_act, load_acc, dec, expire, all_zero, last_sec;

    assign in_run   = (state_q == ST_RUN);
    assign wrap     = in_run && (presc_q == PW'(CLK_FREQ - 1));
    assign load_ok  = preset_ok(preset_bcd);
    assign load_act = load_p && !in_run;
    assign load_acc = load_act && load_ok;
    assign all_zero = &zero;
    // borrow[3] means the chain would underflow, i.e. 00:00 must never be decremented
    assign dec      = wrap && !borrow[3];
    assign last_sec = zero[3] && zero[2] && zero[1] && (digits_bcd[3:0] == 4'd1);
    assign expire   = dec && last_sec;

    bcd_down_digit #(.MAX(DIGIT_MAX), .RST_VAL(DEFAULT_PRESET[3:0])) u_s_ones (
        .clk(clk), .rst(rst), .en(dec), .load(load_acc), .load_val(preset_bcd[3:0]),
        .borrow_in(1'b1), .q(digits_bcd[3:0]), .borrow_out(borrow[0]), .is_zero(zero[0]));
    bcd_down_digit #(.MAX(SEC_TENS_MAX), .RST_VAL(DEFAULT_PRESET[7:4])) u_s_tens (
        .clk(clk), .rst(rst), .en(dec), .load(load_acc), .load_val(preset_bcd[7:4]),
        .borrow_in(borrow[0]), .q(digits_bcd[7:4]), .borrow_out(borrow[1]), .is_zero(zero[1]));
    bcd_down_digit #(.MAX(DIGIT_MAX), .RST_VAL(DEFAULT_PRESET[11:8])) u_m_ones (
        .clk(clk), .rst(rst), .en(dec), .load(load_acc), .load_val(preset_bcd[11:8]),
        .borrow_in(borrow[1]), .q(digits_bcd[11:8]), .borrow_out(borrow[2]), .is_zero(zero[2]));
    bcd_down_digit #(.MAX(DIGIT_MAX), .RST_VAL(DEFAULT_PRESET[15:12])) u_m_tens (
        .clk(clk), .rst(rst), .en(dec), .load(load_acc), .load_val(preset_bcd[15:12]),
        .borrow_in(borrow[2]), .q(digits_bcd[15:12]), .borrow_out(borrow[3]), .is_zero(zero[3]));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Outside RUN a load owns the cycle even when rejected, so it masks start_p
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (expire)       state_d = ST_EXPIRED;
                else if (pause_p) state_d = ST_PAUSE;
            end
            ST_IDLE: begin
                if (load_act)                  state_d = ST_IDLE;
                else if (start_p && !all_zero) state_d = ST_RUN;
            end
            ST_PAUSE: begin
                if (load_acc)     state_d = ST_IDLE;
                else if (load_act) state_d = ST_PAUSE;
                else if (start_p) state_d = ST_RUN;
            end
            default: begin
                if (load_acc) state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        running  = (state_q == ST_RUN);
        expired  = (state_q == ST_EXPIRED);
        sec_tick = sec_tick_q;
        load_err = load_err_q;
        buzzer   = buzzer_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc_q    <= '0;
            buzz_cnt_q <= '0;
            buzzer_q   <= 1'b0;
            sec_tick_q <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            sec_tick_q <= dec;
            load_err_q <= load_act && !load_ok;
            if (load_acc)    presc_q <= '0;
            else if (in_run) presc_q <= wrap ? '0 : presc_q + 1'b1;
            if (load_acc) begin
                buzz_cnt_q <= '0;
                buzzer_q   <= 1'b0;
            end else if (expire) begin
                buzz_cnt_q <= BW'(BUZZ_CYCLES - 1);
                buzzer_q   <= 1'b1;
            end else if (buzzer_q) begin
                if (buzz_cnt_q == '0) buzzer_q <= 1'b0;
                else                  buzz_cnt_q <= buzz_cnt_q - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_game_clock_ctrl.sv
// tb/tb_game_clock_ctrl.sv - directed and random checks of game_clock_ctrl against a seconds-based model
module tb_game_clock_ctrl;

    localparam int CF = 10;
    localparam int BZ = 5;
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_EXP = 3;

    logic        clk, rst, start_p, pause_p, load_p;
    logic [15:0] preset_bcd, digits_bcd;
    logic        running, expired, sec_tick, load_err, buzzer;

    int n_cmp = 0;
    int n_bad = 0;

    int m_st, m_secs, m_presc, m_buzz;
    logic m_tick, m_lerr;

    game_clock_ctrl #(.CLK_FREQ(CF), .DEFAULT_PRESET(16'h1200), .BUZZ_CYCLES(BZ)) dut (
        .clk(clk), .rst(rst), .start_p(start_p), .pause_p(pause_p), .load_p(load_p),
        .preset_bcd(preset_bcd), .digits_bcd(digits_bcd), .running(running), .expired(expired),
        .sec_tick(sec_tick), .load_err(load_err), .buzzer(buzzer));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int s);
        int mm, ss;
        mm = s / 60;
        ss = s % 60;
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
    endfunction

    function automatic logic valid_preset(input logic [15:0] p);
        return p[15:12] <= 9 && p[11:8] <= 9 && p[7:4] <= 5 && p[3:0] <= 9;
    endfunction

    function automatic int to_secs(input logic [15:0] p);
        return (int'(p[15:12]) * 10 + int'(p[11:8])) * 60 + int'(p[7:4]) * 10 + int'(p[3:0]);
    endfunction

    task automatic model_reset();
        m_st = M_IDLE; m_secs = 12 * 60; m_presc = 0; m_buzz = 0; m_tick = 0; m_lerr = 0;
    endtask

    task automatic model_step(input logic s, input logic p, input logic l, input logic [15:0] pr);
        m_tick = 0;
        m_lerr = 0;
        if (m_buzz > 0) m_buzz--;
        if (m_st == M_RUN) begin
            if (m_presc == CF - 1) begin
                m_presc = 0;
                m_tick = 1;
                m_secs--;
            end else begin
                m_presc++;
            end
            if (m_tick && m_secs == 0) begin
                m_st = M_EXP;
                m_buzz = BZ;
            end else if (p) begin
                m_st = M_PAUSE;
            end
        end else if (l) begin
            if (valid_preset(pr)) begin
                m_secs = to_secs(pr); m_presc = 0; m_buzz = 0; m_st = M_IDLE;
            end else begin
                m_lerr = 1;
            end
        end else if (m_st == M_IDLE) begin
            if (s && m_secs != 0) m_st = M_RUN;
        end else if (m_st == M_PAUSE) begin
            if (s) m_st = M_RUN;
        end
    endtask

    task automatic compare_all();
        check("digits", digits_bcd, to_bcd(m_secs));
        check("running", 16'(running), 16'(m_st == M_RUN));
        check("expired", 16'(expired), 16'(m_st == M_EXP));
        check("sec_tick", 16'(sec_tick), 16'(m_tick));
        check("load_err", 16'(load_err), 16'(m_lerr));
        check("buzzer", 16'(buzzer), 16'(m_buzz > 0));
    endtask

    task automatic cyc(input logic s, input logic p, input logic l, input logic [15:0] pr);
        @(negedge clk);
        compare_all();
        start_p = s; pause_p = p; load_p = l; preset_bcd = pr;
        @(posedge clk);
        model_step(s, p, l, pr);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 16'h0000);
    endtask

    task automatic reset_mid(input string tag);
        #3;
        rst = 0;
        start_p = 0; pause_p = 0; load_p = 0;
        #1;
        check({tag, "_digits"}, digits_bcd, 16'h1200);
        check({tag, "_run"}, 16'(running), 16'd0);
        check({tag, "_tick"}, 16'(sec_tick), 16'd0);
        check({tag, "_buzz"}, 16'(buzzer), 16'd0);
        model_reset();
        @(negedge clk);
        rst = 1;
    endtask

    function automatic logic [15:0] rand_preset();
        case ($urandom_range(0, 4))
            0: return 16'($urandom);
            1: return {12'h000, 4'($urandom_range(1, 3))};
            2: return 16'h0000;
            3: return {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                       4'($urandom_range(0, 5)), 4'($urandom_range(0, 9))};
            default: return {8'h00, 4'($urandom_range(0, 1)), 4'($urandom_range(0, 9))};
        endcase
    endfunction

    initial begin
        logic found;
        clk = 0; rst = 1; start_p = 0; pause_p = 0; load_p = 0; preset_bcd = 16'h0000;
        model_reset();
        #2 rst = 0;
        #2;
        check("rst_digits", digits_bcd, 16'h1200);
        check("rst_flags", {11'd0, running, expired, sec_tick, load_err, buzzer}, 16'd0);
        repeat (2) @(negedge clk);
        rst = 1;

        // 1: start from 12:00, first tick after CF cycles
        cyc(1, 0, 0, 16'h0000);
        #1 check("t1_running", 16'(running), 16'd1);
        idle(CF);
        #1 check("t1_tick", 16'(sec_tick), 16'd1);
        check("t1_digits", digits_bcd, 16'h1159);

        // 2: expire from 00:01, buzzer window, start ignored
        cyc(0, 1, 0, 16'h0000);
        cyc(0, 0, 1, 16'h0001);
        cyc(1, 0, 0, 16'h0000);
        idle(CF);
        #1 check("t2_expired", 16'(expired), 16'd1);
        check("t2_digits", digits_bcd, 16'h0000);
        check("t2_buzz_on", 16'(buzzer), 16'd1);
        for (int i = 0; i < BZ; i++) cyc(1, 0, 0, 16'h0000);
        #1 check("t2_buzz_off", 16'(buzzer), 16'd0);
        check("t2_still_exp", 16'(expired), 16'd1);

        // 3: pause keeps partial second
        cyc(0, 0, 1, 16'h0100);
        cyc(1, 0, 0, 16'h0000);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (m_presc == 4) found = 1;
            else cyc(0, 0, 0, 16'h0000);
        end
        check("t3_presc_to", 16'(found), 16'd1);
        cyc(0, 1, 0, 16'h0000);
        idle(50);
        #1 check("t3_hold", digits_bcd, 16'h0100);
        cyc(1, 0, 0, 16'h0000);
        found = 0;
        for (int i = 0; i < 2 * CF && !found; i++) begin
            cyc(0, 0, 0, 16'h0000);
            if (m_tick) found = 1;
        end
        #1 check("t3_tick_to", 16'(found), 16'd1);
        check("t3_digits", digits_bcd, 16'h0059);

        // 4: invalid load in PAUSE, load ignored in RUN
        cyc(0, 1, 0, 16'h0000);
        cyc(0, 0, 1, 16'h0960);
        #1 check("t4_lerr", 16'(load_err), 16'd1);
        check("t4_digits", digits_bcd, 16'h0059);
        cyc(1, 0, 0, 16'h0000);
        cyc(0, 0, 1, 16'h1300);
        #1 check("t4_run_lerr", 16'(load_err), 16'd0);
        check("t4_run", 16'(running), 16'd1);

        // 5: simultaneous requests
        cyc(1, 1, 0, 16'h0000);
        #1 check("t5_to_pause", 16'(running), 16'd0);
        cyc(1, 1, 0, 16'h0000);
        #1 check("t5_to_run", 16'(running), 16'd1);
        cyc(0, 1, 0, 16'h0000);
        cyc(1, 0, 1, 16'h0230);
        #1 check("t5_load_idle", {15'd0, running}, 16'd0);
        check("t5_digits", digits_bcd, 16'h0230);

        // 6: async reset mid-second
        cyc(1, 0, 0, 16'h0000);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (m_presc == 7) found = 1;
            else cyc(0, 0, 0, 16'h0000);
        end
        check("t6_presc_to", 16'(found), 16'd1);
        reset_mid("t6");

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 599) == 0) begin
                @(negedge clk);
                compare_all();
                start_p = 0; pause_p = 0; load_p = 0;
                @(posedge clk);
                model_step(0, 0, 0, 16'h0000);
                reset_mid("rnd_rst");
            end else begin
                cyc($urandom_range(0, 5) == 0, $urandom_range(0, 11) == 0,
                    $urandom_range(0, 9) == 0, rand_preset());
            end
        end
        @(negedge clk);
        compare_all();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
